// File: rtl/rl_seq_pkg.sv
// rl_seq_pkg: state encoding, default sizes and counter-width helper shared by
// the RL policy-path sequencer and its beat counters.
package rl_seq_pkg;
    typedef enum logic [2:0] {
        IDLE,
        S1_RUN,
        S2_RUN,
        S3_RUN,
        CMP_ISSUE,
        CMP_WAIT
    } state_t;

    localparam int S2_BEATS_DEF = 256;
    localparam int S3_BEATS_DEF = 2;
    localparam int TIMEOUT_DEF  = 4095;
    localparam int S2_CW_DEF    = $clog2(S2_BEATS_DEF);
    localparam int WD_W_DEF     = $clog2(TIMEOUT_DEF + 1);

    function automatic int cnt_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rl_layer_sequencer_counter.sv
// rl_beat_counter: modulo-N beat counter; last flags the beat that completes
// a block of N so the caller can advance in the same cycle.
module rl_beat_counter
    import rl_seq_pkg::*;
#(
    parameter int N = 2,
    localparam int W = cnt_width(N)
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         last
);
    assign last = en && count == W'(N - 1);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= last ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/rl_layer_sequencer.sv
// rl_layer_sequencer: sequences stage-1/2/3 GEMMs and the fp16 compare for one
// inference. Define RL_SEQ_WATCHDOG_EN to build the progress watchdog and err flag.
module rl_layer_sequencer
    import rl_seq_pkg::*;
#(
    parameter int S2_BEATS = S2_BEATS_DEF,
    parameter int S3_BEATS = S3_BEATS_DEF,
    parameter int WIDTH    = 16,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             trig,
    output logic             busy,
    output logic             done,
    output logic             action,
    output logic             err,
    output logic             s1_trig,
    input  logic             s1_ovalid,
    output logic             s2_gvalid,
    output logic             s2_ivalid,
    input  logic             s2_ovalid,
    output logic             s3_gvalid,
    output logic             s3_ivalid,
    input  logic             s3_ovalid,
    input  logic [WIDTH-1:0] s3_out,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    output logic             cmp_valid,
    input  logic             cmp_ready,
    input  logic             cmp_rvalid,
    input  logic             cmp_index
);
    localparam int S2_CW = cnt_width(S2_BEATS);
    localparam int S3_CW = cnt_width(S3_BEATS);

    state_t state_q, nxt, state_d;
    logic s2_en_q, s3_en_q, s1_trig_q, done_q, action_q;
    logic [WIDTH-1:0] cmp_a_q, cmp_b_q;
    logic start, s2_beat, s3_beat, s2_last, s3_last, timeout;
    logic [S2_CW-1:0] s2_cnt_unused;
    logic [S3_CW-1:0] s3_cnt;

    assign start     = state_q == IDLE && trig;
    assign s2_beat   = state_q == S2_RUN && s2_ovalid;
    assign s3_beat   = state_q == S3_RUN && s3_ovalid;
    // Enables are decoded combinationally so each stage sees its first beat with zero added latency.
    assign s2_gvalid = (state_q == S1_RUN && s1_ovalid) || s2_en_q;
    assign s2_ivalid = s2_gvalid;
    assign s3_gvalid = s2_last || s3_en_q;
    assign s3_ivalid = s3_gvalid;
    assign busy      = state_q != IDLE;
    assign cmp_valid = state_q == CMP_ISSUE;
    assign s1_trig   = s1_trig_q;
    assign done      = done_q;
    assign action    = action_q;
    assign cmp_a     = cmp_a_q;
    assign cmp_b     = cmp_b_q;

    rl_beat_counter #(.N(S2_BEATS)) u_s2_cnt (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(s2_beat), .clr(state_q == IDLE),
        .count(s2_cnt_unused), .last(s2_last)
    );

    rl_beat_counter #(.N(S3_BEATS)) u_s3_cnt (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(s3_beat), .clr(state_q == IDLE),
        .count(s3_cnt), .last(s3_last)
    );

    always_comb begin
        nxt = state_q;
        unique case (state_q)
            IDLE:      nxt = trig ? S1_RUN : IDLE;
            S1_RUN:    nxt = s1_ovalid ? S2_RUN : S1_RUN;
            S2_RUN:    nxt = s2_last ? S3_RUN : S2_RUN;
            S3_RUN:    nxt = s3_last ? CMP_ISSUE : S3_RUN;
            CMP_ISSUE: nxt = cmp_ready ? CMP_WAIT : CMP_ISSUE;
            CMP_WAIT:  nxt = cmp_rvalid ? IDLE : CMP_WAIT;
            default:   nxt = IDLE;
        endcase
    end

    assign state_d = timeout ? IDLE : nxt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            s2_en_q   <= 1'b0;
            s3_en_q   <= 1'b0;
            s1_trig_q <= 1'b0;
            done_q    <= 1'b0;
            action_q  <= 1'b0;
            cmp_a_q   <= '0;
            cmp_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            s2_en_q   <= state_d == S2_RUN;
            s3_en_q   <= state_d == S3_RUN;
            s1_trig_q <= start;
            done_q    <= state_q == CMP_WAIT && cmp_rvalid;
            if (state_q == CMP_WAIT && cmp_rvalid) action_q <= cmp_index;
            if (s3_beat && s3_cnt == '0) cmp_a_q <= s3_out;
            if (s3_last) cmp_b_q <= s3_out;
        end
    end

`ifdef RL_SEQ_WATCHDOG_EN
    localparam int WD_W = cnt_width(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
    logic err_q, progress;

    assign progress = nxt != state_q || s2_beat || s3_beat;
    assign timeout  = state_q != IDLE && !progress && wd_q == WD_W'(TIMEOUT - 1);
    assign err      = err_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= (state_q == IDLE || progress) ? '0 : wd_q + 1'b1;
            err_q <= timeout || (err_q && !start);
        end
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT;
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_rl_layer_sequencer.sv
// tb_rl_layer_sequencer: vector table plus randomized stage/compare models for
// rl_layer_sequencer; watchdog checks follow RL_SEQ_WATCHDOG_EN.
module tb_rl_layer_sequencer;
    localparam int S2B = 256;
    localparam int TO  = 16;
`ifdef RL_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] qa, qb;
        logic        idx;
        int          gap_at, gap_len, rdy_dly, trig_at;
        logic [15:0] exp_a, exp_b;
        logic        exp_act;
        bit          exp_abort;
    } vec_t;

    logic sys_clk = 1'b0, sys_rst = 1'b1, trig = 1'b0;
    logic s1_ovalid = 1'b0, s2_ovalid = 1'b0, s3_ovalid = 1'b0;
    logic [15:0] s3_out = '0;
    logic cmp_ready = 1'b0, cmp_rvalid = 1'b0, cmp_index = 1'b0;
    logic busy, done, action, err, s1_trig, s2_gvalid, s2_ivalid, s3_gvalid, s3_ivalid, cmp_valid;
    logic [15:0] cmp_a, cmp_b;
    logic [9:0] ctrl;

    int checks = 0, errors = 0;
    int done_cnt = 0, trig_cnt = 0;
    bit exp_s2_en = 0, exp_s3_en = 0, exp_err = 0;
    logic exp_action = 1'b0;
    vec_t tbl[6];

    rl_layer_sequencer #(.S2_BEATS(S2B), .S3_BEATS(2), .WIDTH(16), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .trig(trig), .busy(busy), .done(done),
        .action(action), .err(err), .s1_trig(s1_trig), .s1_ovalid(s1_ovalid),
        .s2_gvalid(s2_gvalid), .s2_ivalid(s2_ivalid), .s2_ovalid(s2_ovalid),
        .s3_gvalid(s3_gvalid), .s3_ivalid(s3_ivalid), .s3_ovalid(s3_ovalid), .s3_out(s3_out),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
        .cmp_rvalid(cmp_rvalid), .cmp_index(cmp_index)
    );

    always #5 sys_clk = ~sys_clk;
    assign ctrl = {busy, done, err, s1_trig, s2_gvalid, s2_ivalid, s3_gvalid, s3_ivalid, cmp_valid, action};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Reference: first stage-3 value is operand a, second is b, the compare index is the action.
    function automatic vec_t model(input vec_t v);
        v.exp_a     = v.qa;
        v.exp_b     = v.qb;
        v.exp_act   = v.idx;
        v.exp_abort = WD_EN && v.gap_len >= TO;
        return v;
    endfunction

    always @(negedge sys_clk) begin
        if (done) done_cnt++;
        if (s1_trig) trig_cnt++;
        chk("s2_en", {30'd0, s2_gvalid, s2_ivalid}, {30'd0, exp_s2_en, exp_s2_en});
        chk("s3_en", {30'd0, s3_gvalid, s3_ivalid}, {30'd0, exp_s3_en, exp_s3_en});
    end

    task automatic start_inf();
        chk("err_pre", err, exp_err);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        exp_err = 0;
        chk("s1_trig_hi", s1_trig, 1);
        chk("busy_hi", busy, 1);
        chk("err_clr", err, 0);
        tick();
        chk("s1_trig_lo", s1_trig, 0);
        repeat ($urandom_range(0, 2)) tick();
        s1_ovalid = 1'b1;
        exp_s2_en = 1;
        tick();
        s1_ovalid = 1'b0;
    endtask

    task automatic run_s2(input int trig_at, input int gap_at, input int gap_len, input bit exp_abort);
        for (int b = 0; b < S2B; b++) begin
            while ($urandom_range(0, 3) == 0) tick();
            s2_ovalid = 1'b1;
            trig = b == trig_at;
            exp_s3_en = b == S2B - 1;
            tick();
            s2_ovalid = 1'b0;
            trig = 1'b0;
            if (b == S2B - 1) exp_s2_en = 0;
            for (int k = 1; b == gap_at && k <= gap_len; k++) begin
                tick();
                if (exp_abort && k == TO) begin
                    exp_s2_en = 0;
                    exp_err = 1;
                    chk("wd_err", err, 1);
                    chk("wd_busy", busy, 0);
                    chk("wd_done", done, 0);
                    chk("wd_cmp_valid", cmp_valid, 0);
                    return;
                end
                chk("gap_busy", busy, 1);
                chk("gap_err", err, 0);
            end
        end
    endtask

    task automatic run_s3_cmp(input vec_t v);
        repeat ($urandom_range(0, 2)) tick();
        s3_ovalid = 1'b1;
        s3_out = v.qa;
        tick();
        s3_ovalid = 1'b0;
        s3_out = 16'($urandom);
        repeat ($urandom_range(0, 2)) tick();
        s3_ovalid = 1'b1;
        s3_out = v.qb;
        tick();
        s3_ovalid = 1'b0;
        s3_out = 16'($urandom);
        exp_s3_en = 0;
        for (int i = 0; i < v.rdy_dly; i++) begin
            chk("cmp_valid_hold", cmp_valid, 1);
            chk("cmp_a_hold", cmp_a, v.exp_a);
            chk("cmp_b_hold", cmp_b, v.exp_b);
            tick();
        end
        chk("cmp_valid", cmp_valid, 1);
        chk("cmp_a", cmp_a, v.exp_a);
        chk("cmp_b", cmp_b, v.exp_b);
        cmp_ready = 1'b1;
        tick();
        cmp_ready = 1'b0;
        chk("cmp_valid_drop", cmp_valid, 0);
        repeat ($urandom_range(1, 3)) begin
            s1_ovalid = 1'($urandom_range(0, 1));
            s2_ovalid = 1'($urandom_range(0, 1));
            s3_ovalid = 1'($urandom_range(0, 1));
            s3_out = 16'($urandom);
            cmp_index = 1'($urandom_range(0, 1));
            tick();
            chk("wait_done", done, 0);
            chk("wait_busy", busy, 1);
            chk("wait_action", action, exp_action);
        end
        {s1_ovalid, s2_ovalid, s3_ovalid} = 3'b000;
        cmp_rvalid = 1'b1;
        cmp_index = v.idx;
        tick();
        cmp_rvalid = 1'b0;
        cmp_index = ~v.idx;
        chk("done_hi", done, 1);
        chk("action", action, v.exp_act);
        chk("busy_lo", busy, 0);
        exp_action = v.exp_act;
        tick();
        chk("done_lo", done, 0);
        chk("action_hold", action, v.exp_act);
        chk("cmp_a_final", cmp_a, v.exp_a);
        chk("cmp_b_final", cmp_b, v.exp_b);
    endtask

    task automatic run_inference(input vec_t v);
        int d0 = done_cnt, t0 = trig_cnt;
        start_inf();
        run_s2(v.trig_at, v.gap_at, v.gap_len, v.exp_abort);
        if (!v.exp_abort) run_s3_cmp(v);
        tick();
        chk("done_pulses", done_cnt - d0, v.exp_abort ? 0 : 1);
        chk("s1_trig_pulses", trig_cnt - t0, 1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ctrl", ctrl, 0);
        chk("rst_cmp", {cmp_a, cmp_b}, 0);
        sys_rst = 1'b0;
        tick();
        tbl[0] = '{16'h3C00, 16'h4000, 1'b1, -1, 0, 0, -1, 16'h0, 16'h0, 1'b0, 1'b0};
        tbl[1] = '{16'h3800, 16'h4200, 1'b0, 100, 5, 2, -1, 16'h0, 16'h0, 1'b0, 1'b0};
        tbl[2] = '{16'hC000, 16'h3C00, 1'b1, -1, 0, 7, -1, 16'h0, 16'h0, 1'b0, 1'b0};
        tbl[3] = '{16'h1234, 16'h5678, 1'b0, -1, 0, 1, 50, 16'h0, 16'h0, 1'b0, 1'b0};
        tbl[4] = '{16'hAAAA, 16'h5555, 1'b1, 10, 40, 0, -1, 16'h0, 16'h0, 1'b0, 1'b0};
        tbl[5] = '{16'h3C00, 16'h4000, 1'b1, -1, 0, 0, -1, 16'h0, 16'h0, 1'b0, 1'b0};
        foreach (tbl[i]) tbl[i] = model(tbl[i]);
        foreach (tbl[i]) run_inference(tbl[i]);

        // Reset in S3_RUN after operand a has been captured.
        start_inf();
        run_s2(-1, -1, 0, 1'b0);
        s3_ovalid = 1'b1;
        s3_out = 16'h1111;
        tick();
        s3_ovalid = 1'b0;
        sys_rst = 1'b1;
        exp_s2_en = 0;
        exp_s3_en = 0;
        exp_err = 0;
        exp_action = 1'b0;
        #2;
        chk("midrst_ctrl", ctrl, 0);
        chk("midrst_cmp", {cmp_a, cmp_b}, 0);
        tick();
        chk("midrst_ctrl_edge", ctrl, 0);
        chk("midrst_cmp_edge", {cmp_a, cmp_b}, 0);
        sys_rst = 1'b0;
        tick();
        run_inference(tbl[1]);

        for (int n = 0; n < 6; n++) begin
            vec_t v;
            v.qa      = 16'($urandom);
            v.qb      = 16'($urandom);
            v.idx     = 1'($urandom_range(0, 1));
            v.gap_at  = $urandom_range(0, 254);
            v.gap_len = $urandom_range(0, 6);
            v.rdy_dly = $urandom_range(0, 7);
            v.trig_at = $urandom_range(0, 1) == 1 ? int'($urandom_range(0, 255)) : -1;
            run_inference(model(v));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
